// File: rtl/console_pkg.sv
// Shared encodings and constants for the console UART bridge.
// Both the TX FSM in the top and the RX sub-module use the same 2-bit state codes.
package console_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        UART_IDLE = 1'b1;

endpackage

// File: rtl/console_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start validation at mid-bit, LSB-first sampling.
// Emits a single-cycle byte strobe or frame-error strobe in the stop-bit sample cycle.
module console_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  import console_pkg::*;

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_prev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  assign rx_s   = sync_q[1];
  assign byte_o = shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= {2{UART_IDLE}};
      rx_prev_q <= UART_IDLE;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Half a bit in: a line back high means the falling edge was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            byte_valid_o = 1'b1;
          end else begin
            frame_err_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/console_uart_bridge.sv
// Console port far-end: serialises CONSOLE_OUT bytes as 8N1 on UART_TX and presents
// bytes received on UART_RX through the CONSOLE_IN valid/ack holding register.
module console_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] CONSOLE_OUT,
  input  logic       CONSOLE_OUT_valid,
  output logic       CONSOLE_OUT_ready,
  output logic [7:0] CONSOLE_IN,
  output logic       CONSOLE_IN_valid,
  input  logic       CONSOLE_IN_ack,
  output logic       UART_TX,
  input  logic       UART_RX,
  output logic       RX_OVERRUN,
  output logic       RX_FRAME_ERR
);
  import console_pkg::*;

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  // ---------------- TX ----------------
  state_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;

  assign CONSOLE_OUT_ready = (tx_state_q == IDLE);
  assign UART_TX           = tx_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= UART_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // The line level is registered alongside the state so each bit changes on a clean edge.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      IDLE: begin
        tx_d = UART_IDLE;
        if (CONSOLE_OUT_valid) begin
          tx_shift_d = CONSOLE_OUT;
          tx_cnt_d   = '0;
          tx_state_d = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = STOP;
            tx_d       = UART_IDLE;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_d       = UART_IDLE;
      end
    endcase
  end

  // ---------------- RX ----------------
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_err;

  console_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .rx_i         (UART_RX),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (rx_frame_err)
  );

  logic [7:0] in_data_q, in_data_d;
  logic       in_valid_q, in_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  assign CONSOLE_IN       = in_data_q;
  assign CONSOLE_IN_valid = in_valid_q;
  assign RX_OVERRUN       = overrun_q;
  assign RX_FRAME_ERR     = frame_err_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // An ack coinciding with a delivery frees the slot just in time, so the new byte wins.
  always_comb begin
    in_data_d   = in_data_q;
    in_valid_d  = in_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (rx_byte_valid) begin
      if (!in_valid_q || CONSOLE_IN_ack) begin
        in_data_d  = rx_byte;
        in_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (in_valid_q && CONSOLE_IN_ack) begin
      in_valid_d = 1'b0;
    end
    if (rx_frame_err) begin
      frame_err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_console_uart_bridge.sv
// Directed bench for console_uart_bridge at 16 clocks per bit; inputs change and
// outputs are sampled on the falling clock edge.
module tb_console_uart_bridge;

  localparam int unsigned CPB = 16;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] CONSOLE_OUT;
  logic       CONSOLE_OUT_valid;
  logic       CONSOLE_OUT_ready;
  logic [7:0] CONSOLE_IN;
  logic       CONSOLE_IN_valid;
  logic       CONSOLE_IN_ack;
  logic       UART_TX;
  logic       UART_RX;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;

  int n_checks = 0;
  int n_errors = 0;
  int hs_count = 0;

  console_uart_bridge #(
    .CLKS_PER_BIT (CPB)
  ) u_dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .CONSOLE_OUT       (CONSOLE_OUT),
    .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
    .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
    .CONSOLE_IN        (CONSOLE_IN),
    .CONSOLE_IN_valid  (CONSOLE_IN_valid),
    .CONSOLE_IN_ack    (CONSOLE_IN_ack),
    .UART_TX           (UART_TX),
    .UART_RX           (UART_RX),
    .RX_OVERRUN        (RX_OVERRUN),
    .RX_FRAME_ERR      (RX_FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (CONSOLE_OUT_valid && CONSOLE_OUT_ready) hs_count <= hs_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  // Called on a falling edge; drives start, 8 data bits LSB first, then the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = f[i];
      repeat (CPB) @(negedge CLK);
    end
    UART_RX = 1'b1;
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!CONSOLE_IN_valid && lat < limit);
    check("rx_valid_rise", CONSOLE_IN_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [9:0] line;
    int lat;

    CONSOLE_OUT       = 8'h00;
    CONSOLE_OUT_valid = 1'b0;
    CONSOLE_IN_ack    = 1'b0;
    UART_RX           = 1'b1;
    RESET_N           = 1'b1;
    @(negedge CLK);
    do_reset();

    // Reset state after 50 idle cycles
    repeat (50) @(negedge CLK);
    check("rst_tx", UART_TX, 1);
    check("rst_ready", CONSOLE_OUT_ready, 1);
    check("rst_in_valid", CONSOLE_IN_valid, 0);
    check("rst_in_data", CONSOLE_IN, 8'h00);
    check("rst_overrun", RX_OVERRUN, 0);
    check("rst_frame_err", RX_FRAME_ERR, 0);

    // TX 0x41: start, 1,0,0,0,0,0,1,0, stop
    CONSOLE_OUT       = 8'h41;
    CONSOLE_OUT_valid = 1'b1;
    @(negedge CLK);
    check("tx_ready_low", CONSOLE_OUT_ready, 0);
    CONSOLE_OUT_valid = 1'b0;
    line = '0;
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? 8 : 16) @(negedge CLK);
      line[i] = UART_TX;
    end
    check("tx_line_0x41", line, 10'b1010000010);
    repeat (7) @(negedge CLK);
    check("tx_ready_159", CONSOLE_OUT_ready, 0);
    @(negedge CLK);
    check("tx_ready_160", CONSOLE_OUT_ready, 1);
    check("tx_handshakes", hs_count, 1);

    // RX 0x5A, ack three cycles after valid
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_valid(400, lat);
        check("rx_latency_ok", (lat >= 154 && lat <= 156), 1);
        repeat (3) @(negedge CLK);
        check("rx_valid_pre_ack", CONSOLE_IN_valid, 1);
        check("rx_data_5a", CONSOLE_IN, 8'h5A);
        CONSOLE_IN_ack = 1'b1;
        @(negedge CLK);
        CONSOLE_IN_ack = 1'b0;
        check("rx_valid_post_ack", CONSOLE_IN_valid, 0);
        check("rx_data_held", CONSOLE_IN, 8'h5A);
      end
    join
    repeat (4) @(negedge CLK);

    // Two frames without ack: overrun keeps the first byte
    send_frame(8'h11, 1'b1);
    check("ovr_first_valid", CONSOLE_IN_valid, 1);
    check("ovr_first_data", CONSOLE_IN, 8'h11);
    check("ovr_none_yet", RX_OVERRUN, 0);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge CLK);
    check("ovr_data_kept", CONSOLE_IN, 8'h11);
    check("ovr_flag", RX_OVERRUN, 1);
    check("ovr_valid", CONSOLE_IN_valid, 1);
    check("ovr_no_frame_err", RX_FRAME_ERR, 0);

    // Same pair, ack in the 0x22 delivery cycle (fall + 2 + 8 + 9*16)
    do_reset();
    send_frame(8'h11, 1'b1);
    check("ack_first_data", CONSOLE_IN, 8'h11);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(negedge CLK);
        CONSOLE_IN_ack = 1'b1;
        @(negedge CLK);
        CONSOLE_IN_ack = 1'b0;
      end
    join
    repeat (4) @(negedge CLK);
    check("ack_new_data", CONSOLE_IN, 8'h22);
    check("ack_valid_held", CONSOLE_IN_valid, 1);
    check("ack_no_overrun", RX_OVERRUN, 0);

    // Stop bit low: frame error, nothing delivered
    do_reset();
    send_frame(8'h33, 1'b0);
    repeat (20) @(negedge CLK);
    check("ferr_flag", RX_FRAME_ERR, 1);
    check("ferr_valid", CONSOLE_IN_valid, 0);
    check("ferr_data", CONSOLE_IN, 8'h00);

    // 4-cycle glitch is rejected at the mid-start sample
    do_reset();
    UART_RX = 1'b0;
    repeat (4) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (200) @(negedge CLK);
    check("glitch_valid", CONSOLE_IN_valid, 0);
    check("glitch_frame_err", RX_FRAME_ERR, 0);
    check("glitch_overrun", RX_OVERRUN, 0);
    check("glitch_data", CONSOLE_IN, 8'h00);

    // Asynchronous reset in the middle of a TX frame
    CONSOLE_OUT       = 8'h00;
    CONSOLE_OUT_valid = 1'b1;
    @(negedge CLK);
    CONSOLE_OUT_valid = 1'b0;
    repeat (40) @(negedge CLK);
    check("midtx_line_low", UART_TX, 0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("midtx_rst_line", UART_TX, 1);
    check("midtx_rst_ready", CONSOLE_OUT_ready, 1);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK);
    check("midtx_idle_after", UART_TX, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
